// File: rtl/mult_booth_if.sv
// Handshake and operand/result bundle between the MIPS control unit (master)
// and the sequential Booth multiplier (slave).
// Optional: MULT_UNSIGNED_EN adds the is_unsigned request bit for MULTU.
interface mult_booth_if #(
  parameter int WIDTH = 32
);
  logic             mult_start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
`ifdef MULT_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULT_UNSIGNED_EN
  modport master (
    output mult_start, multiplicand, multiplier, is_unsigned,
    input  busy, done, hi, lo
  );
  modport slave (
    input  mult_start, multiplicand, multiplier, is_unsigned,
    output busy, done, hi, lo
  );
`else
  modport master (
    output mult_start, multiplicand, multiplier,
    input  busy, done, hi, lo
  );
  modport slave (
    input  mult_start, multiplicand, multiplier,
    output busy, done, hi, lo
  );
`endif
endinterface

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier for the multicycle MIPS datapath.
// One Booth step per clock; the 2*WIDTH-bit product lands in HI/LO together
// with a one-cycle done pulse. Operands are captured on the start edge.
// Optional: define MULT_UNSIGNED_EN to add is_unsigned (MULTU support); every
// operation then runs WIDTH+1 steps on zero/sign-extended WIDTH+1-bit operands.
module mult_booth #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  mult_booth_if.slave   bus
);

`ifdef MULT_UNSIGNED_EN
  localparam int QW    = WIDTH + 1;
  localparam int STEPS = WIDTH + 1;
`else
  localparam int QW    = WIDTH;
  localparam int STEPS = WIDTH;
`endif
  localparam int SW = WIDTH + 1 + QW + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH:0]   a_q, a_d;
  logic signed [WIDTH:0]   m_q, m_d;
  logic [QW-1:0]           q_q, q_d;
  logic                    q1_q, q1_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        hi_q, hi_d;
  logic [WIDTH-1:0]        lo_q, lo_d;

  logic signed [WIDTH:0]   m_ext;
  logic [QW-1:0]           q_ext;
  logic [WIDTH-1:0]        prod_hi;
  logic [WIDTH-1:0]        prod_lo;

  // One Booth step: conditional add/subtract of M, then arithmetic shift of
  // {A,Q,q_1} right by one. A is one bit wider than the operand so that
  // subtracting the most negative multiplicand cannot overflow.
  function automatic logic [SW-1:0] booth_step(
    input logic signed [WIDTH:0] a,
    input logic signed [WIDTH:0] m,
    input logic [QW-1:0]         q,
    input logic                  q1
  );
    logic signed [WIDTH:0] sum;
    case ({q[0], q1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    return {sum[WIDTH], sum, q};
  endfunction

  // Operand extension on capture and product extraction from {A,Q}.
  always_comb begin
`ifdef MULT_UNSIGNED_EN
    m_ext   = {(~bus.is_unsigned & bus.multiplicand[WIDTH-1]), bus.multiplicand};
    q_ext   = {(~bus.is_unsigned & bus.multiplier[WIDTH-1]), bus.multiplier};
    prod_hi = {a_q[WIDTH-2:0], q_q[WIDTH]};
    prod_lo = q_q[WIDTH-1:0];
`else
    m_ext   = {bus.multiplicand[WIDTH-1], bus.multiplicand};
    q_ext   = bus.multiplier;
    prod_hi = a_q[WIDTH-1:0];
    prod_lo = q_q;
`endif
  end

  // Next-state and datapath update: capture in IDLE, step in RUN, publish in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (bus.mult_start) begin
          a_d     = '0;
          m_d     = m_ext;
          q_d     = q_ext;
          q1_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        {a_d, q_d, q1_d} = booth_step(a_q, m_q, q_q, q1_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        hi_d    = prod_hi;
        lo_d    = prod_lo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
